// File: rtl/rename_register_file.sv
// Architectural register file with per-register ROB rename tags,
// a same-cycle commit bypass and branch checkpoints of the rename state.
//
// Ports:
//   clockIn, resetIn          clock; synchronous active-high reset
//   clearIn                   pipeline flush, drops all busy bits
//   readyIn, readAddr         latch per-port source register index
//   rfUpdate*                 rename request (dest, producing ROB id)
//   regUpdate*                ROB commit (dest, value, ROB id)
//   robDep/robReady/robValue  per-port tag lookup into the ROB
//   rsDirty/rsDependency/rsValue  per-port operand result
//   ckptSave*/ckptRestore*    snapshot / restore of busy+tag state
module rename_register_file #(
    parameter int ROB_WIDTH  = 4,
    parameter int READ_PORTS = 2,
    parameter int CKPT_WIDTH = 2
) (
    input  logic                             clockIn,
    input  logic                             resetIn,
    input  logic                             clearIn,
    input  logic                             readyIn,
    input  logic [5*READ_PORTS-1:0]          readAddr,
    input  logic                             rfUpdateValid,
    input  logic [4:0]                       rfUpdateDest,
    input  logic [ROB_WIDTH-1:0]             rfUpdateRobId,
    input  logic                             regUpdateValid,
    input  logic [4:0]                       regUpdateDest,
    input  logic [31:0]                      regUpdateValue,
    input  logic [ROB_WIDTH-1:0]             regUpdateRobId,
    output logic [ROB_WIDTH*READ_PORTS-1:0]  robDep,
    input  logic [READ_PORTS-1:0]            robReady,
    input  logic [32*READ_PORTS-1:0]         robValue,
    output logic [READ_PORTS-1:0]            rsDirty,
    output logic [ROB_WIDTH*READ_PORTS-1:0]  rsDependency,
    output logic [32*READ_PORTS-1:0]         rsValue,
    input  logic                             ckptSaveValid,
    input  logic [CKPT_WIDTH-1:0]            ckptSaveId,
    input  logic                             ckptRestoreValid,
    input  logic [CKPT_WIDTH-1:0]            ckptRestoreId
);

    localparam int NSLOT = 1 << CKPT_WIDTH;

    typedef logic [ROB_WIDTH-1:0] tag_t;

    logic [31:0][31:0]             val_q, val_d;
    logic [31:0]                   busy_q, busy_d;
    tag_t [31:0]                   tag_q, tag_d;
    logic [NSLOT-1:0][31:0]        ckb_q, ckb_d;
    tag_t [NSLOT-1:0][31:0]        ckt_q, ckt_d;
    logic [READ_PORTS-1:0][4:0]    ra_q, ra_d;

    logic commit_en;
    logic rename_en;

    assign commit_en = regUpdateValid && (regUpdateDest != 5'd0);
    assign rename_en = rfUpdateValid && (rfUpdateDest != 5'd0);

    always_comb begin
        val_d  = val_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        ckb_d  = ckb_q;
        ckt_d  = ckt_q;
        ra_d   = ra_q;

        if (readyIn) begin
            for (int p = 0; p < READ_PORTS; p++) begin
                ra_d[p] = readAddr[5*p +: 5];
            end
        end

        // Commit writes the value unconditionally; busy is only released
        // when the committing entry is still the register's producer.
        if (commit_en) begin
            val_d[regUpdateDest] = regUpdateValue;
            if (tag_q[regUpdateDest] == regUpdateRobId) begin
                busy_d[regUpdateDest] = 1'b0;
            end
            for (int s = 0; s < NSLOT; s++) begin
                if (ckt_q[s][regUpdateDest] == regUpdateRobId) begin
                    ckb_d[s][regUpdateDest] = 1'b0;
                end
            end
        end

        // Applied after the commit release so rename wins on the same reg.
        if (rename_en) begin
            busy_d[rfUpdateDest] = 1'b1;
            tag_d[rfUpdateDest]  = rfUpdateRobId;
        end

        if (clearIn) begin
            busy_d = '0;
            tag_d  = tag_q;
            ckb_d  = '0;
        end else if (ckptRestoreValid) begin
            busy_d = ckb_d[ckptRestoreId];
            tag_d  = ckt_q[ckptRestoreId];
        end

        // Snapshot takes the fully resolved live next-state.
        if (ckptSaveValid) begin
            ckb_d[ckptSaveId] = busy_d;
            ckt_d[ckptSaveId] = tag_d;
        end
    end

    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            val_q  <= '0;
            busy_q <= '0;
            tag_q  <= '0;
            ckb_q  <= '0;
            ckt_q  <= '0;
            ra_q   <= '0;
        end else begin
            val_q  <= val_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
            ckb_q  <= ckb_d;
            ckt_q  <= ckt_d;
            ra_q   <= ra_d;
        end
    end

    always_comb begin
        logic [4:0] r;
        tag_t       t;
        r            = '0;
        t            = '0;
        robDep       = '0;
        rsDependency = '0;
        rsDirty      = '0;
        rsValue      = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            r = ra_q[p];
            t = tag_q[r];
            robDep[ROB_WIDTH*p +: ROB_WIDTH]       = t;
            rsDependency[ROB_WIDTH*p +: ROB_WIDTH] = t;
            if (r == 5'd0) begin
                rsValue[32*p +: 32] = '0;
            end else if (busy_q[r] && regUpdateValid &&
                         regUpdateDest == r &&
                         regUpdateRobId == t) begin
                rsValue[32*p +: 32] = regUpdateValue;
            end else if (busy_q[r] && robReady[p]) begin
                rsValue[32*p +: 32] = robValue[32*p +: 32];
            end else if (busy_q[r]) begin
                rsDirty[p]          = 1'b1;
                rsValue[32*p +: 32] = val_q[r];
            end else begin
                rsValue[32*p +: 32] = val_q[r];
            end
        end
    end

endmodule

// File: tb/tb_rename_register_file.sv
// Self-checking bench for rename_register_file: directed walk-throughs
// followed by random traffic compared against an array-based model.
module tb_rename_register_file;

    localparam int RW = 4;
    localparam int RP = 2;
    localparam int CW = 2;
    localparam int NS = 1 << CW;

    logic            clk = 1'b0;
    logic            resetIn, clearIn, readyIn;
    logic [5*RP-1:0] readAddr;
    logic            rfUpdateValid;
    logic [4:0]      rfUpdateDest;
    logic [RW-1:0]   rfUpdateRobId;
    logic            regUpdateValid;
    logic [4:0]      regUpdateDest;
    logic [31:0]     regUpdateValue;
    logic [RW-1:0]   regUpdateRobId;
    logic [RW*RP-1:0] robDep;
    logic [RP-1:0]   robReady;
    logic [32*RP-1:0] robValue;
    logic [RP-1:0]   rsDirty;
    logic [RW*RP-1:0] rsDependency;
    logic [32*RP-1:0] rsValue;
    logic            ckptSaveValid;
    logic [CW-1:0]   ckptSaveId;
    logic            ckptRestoreValid;
    logic [CW-1:0]   ckptRestoreId;

    int errors = 0;
    int checks = 0;

    logic [31:0]   mval[32];
    bit            mbusy[32];
    logic [RW-1:0] mtag[32];
    bit            sbusy[NS][32];
    logic [RW-1:0] stag[NS][32];
    logic [4:0]    mra[RP];

    always #5 clk = ~clk;

    rename_register_file #(
        .ROB_WIDTH(RW), .READ_PORTS(RP), .CKPT_WIDTH(CW)
    ) dut (
        .clockIn(clk), .resetIn(resetIn), .clearIn(clearIn),
        .readyIn(readyIn), .readAddr(readAddr),
        .rfUpdateValid(rfUpdateValid), .rfUpdateDest(rfUpdateDest),
        .rfUpdateRobId(rfUpdateRobId),
        .regUpdateValid(regUpdateValid), .regUpdateDest(regUpdateDest),
        .regUpdateValue(regUpdateValue), .regUpdateRobId(regUpdateRobId),
        .robDep(robDep), .robReady(robReady), .robValue(robValue),
        .rsDirty(rsDirty), .rsDependency(rsDependency), .rsValue(rsValue),
        .ckptSaveValid(ckptSaveValid), .ckptSaveId(ckptSaveId),
        .ckptRestoreValid(ckptRestoreValid), .ckptRestoreId(ckptRestoreId)
    );

    task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic check_model();
        for (int p = 0; p < RP; p++) begin
            logic [4:0]    r;
            logic [RW-1:0] t;
            logic          dirty;
            logic [31:0]   v;
            r     = mra[p];
            t     = mtag[r];
            dirty = 1'b0;
            v     = '0;
            if (r == 5'd0) begin
                v = '0;
            end else if (mbusy[r] && regUpdateValid &&
                         regUpdateDest == r && regUpdateRobId == t) begin
                v = regUpdateValue;
            end else if (mbusy[r] && robReady[p]) begin
                v = robValue[32*p +: 32];
            end else if (mbusy[r]) begin
                dirty = 1'b1;
            end else begin
                v = mval[r];
            end
            chk($sformatf("dirty%0d", p), 32'(rsDirty[p]), 32'(dirty));
            chk($sformatf("dep%0d", p), 32'(rsDependency[RW*p +: RW]), 32'(t));
            chk($sformatf("robdep%0d", p), 32'(robDep[RW*p +: RW]), 32'(t));
            if (!dirty) begin
                chk($sformatf("value%0d", p), rsValue[32*p +: 32], v);
            end
        end
    endtask

    task automatic model_edge();
        bit            nb[32];
        logic [RW-1:0] nt[32];
        if (resetIn) begin
            for (int i = 0; i < 32; i++) begin
                mval[i]  = '0;
                mbusy[i] = 1'b0;
                mtag[i]  = '0;
                for (int s = 0; s < NS; s++) begin
                    sbusy[s][i] = 1'b0;
                    stag[s][i]  = '0;
                end
            end
            for (int p = 0; p < RP; p++) mra[p] = '0;
            return;
        end
        if (readyIn) begin
            for (int p = 0; p < RP; p++) mra[p] = readAddr[5*p +: 5];
        end
        nb = mbusy;
        nt = mtag;
        if (regUpdateValid && regUpdateDest != 0) begin
            mval[regUpdateDest] = regUpdateValue;
            if (mtag[regUpdateDest] == regUpdateRobId &&
                !(rfUpdateValid && rfUpdateDest == regUpdateDest))
                nb[regUpdateDest] = 1'b0;
            for (int s = 0; s < NS; s++) begin
                if (stag[s][regUpdateDest] == regUpdateRobId)
                    sbusy[s][regUpdateDest] = 1'b0;
            end
        end
        if (rfUpdateValid && rfUpdateDest != 0) begin
            nb[rfUpdateDest] = 1'b1;
            nt[rfUpdateDest] = rfUpdateRobId;
        end
        if (clearIn) begin
            for (int i = 0; i < 32; i++) begin
                nb[i] = 1'b0;
                for (int s = 0; s < NS; s++) sbusy[s][i] = 1'b0;
            end
            nt = mtag;
        end else if (ckptRestoreValid) begin
            nb = sbusy[ckptRestoreId];
            nt = stag[ckptRestoreId];
        end
        if (ckptSaveValid) begin
            sbusy[ckptSaveId] = nb;
            stag[ckptSaveId]  = nt;
        end
        mbusy = nb;
        mtag  = nt;
    endtask

    task automatic idle();
        resetIn          = 1'b0;
        clearIn          = 1'b0;
        readyIn          = 1'b0;
        rfUpdateValid    = 1'b0;
        rfUpdateDest     = '0;
        rfUpdateRobId    = '0;
        regUpdateValid   = 1'b0;
        regUpdateDest    = '0;
        regUpdateValue   = '0;
        regUpdateRobId   = '0;
        robReady         = '0;
        robValue         = '0;
        ckptSaveValid    = 1'b0;
        ckptSaveId       = '0;
        ckptRestoreValid = 1'b0;
        ckptRestoreId    = '0;
    endtask

    task automatic settle();
        #2;
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rename(input logic [4:0] d, input logic [RW-1:0] id);
        rfUpdateValid = 1'b1;
        rfUpdateDest  = d;
        rfUpdateRobId = id;
    endtask

    task automatic commit(input logic [4:0] d, input logic [RW-1:0] id,
                          input logic [31:0] v);
        regUpdateValid = 1'b1;
        regUpdateDest  = d;
        regUpdateRobId = id;
        regUpdateValue = v;
    endtask

    initial begin
        idle();
        readAddr = '0;
        resetIn  = 1'b1;
        tick();
        tick();

        // Reset state, then read x5
        idle();
        readyIn  = 1'b1;
        readAddr = {5'd0, 5'd5};
        settle();
        chk("rst_dep0", 32'(rsDependency[RW-1:0]), 32'd0);
        tick();
        idle();
        settle();
        chk("rst_dirty0", 32'(rsDirty[0]), 32'd0);
        chk("rst_val0", rsValue[31:0], 32'd0);
        chk("rst_robdep0", 32'(robDep[RW-1:0]), 32'd0);
        tick();

        // Rename x5 -> ROB 3, then ROB forwarding
        rename(5'd5, 4'd3);
        settle();
        tick();
        idle();
        settle();
        chk("ren_dirty", 32'(rsDirty[0]), 32'd1);
        chk("ren_dep", 32'(rsDependency[RW-1:0]), 32'd3);
        robReady[0]     = 1'b1;
        robValue[31:0]  = 32'h55;
        settle();
        chk("fwd_dirty", 32'(rsDirty[0]), 32'd0);
        chk("fwd_val", rsValue[31:0], 32'h55);
        tick();

        // Commit bypass on x7
        idle();
        readyIn  = 1'b1;
        readAddr = {5'd0, 5'd7};
        rename(5'd7, 4'd2);
        settle();
        tick();
        idle();
        commit(5'd7, 4'd2, 32'hDEAD);
        settle();
        chk("byp_dirty", 32'(rsDirty[0]), 32'd0);
        chk("byp_val", rsValue[31:0], 32'hDEAD);
        tick();
        idle();
        settle();
        chk("arr_dirty", 32'(rsDirty[0]), 32'd0);
        chk("arr_val", rsValue[31:0], 32'hDEAD);
        tick();

        // Stale commit does not release a newer rename
        rename(5'd7, 4'd2);
        settle();
        tick();
        rename(5'd7, 4'd4);
        settle();
        tick();
        idle();
        commit(5'd7, 4'd2, 32'hBEEF);
        settle();
        chk("stale_dirty", 32'(rsDirty[0]), 32'd1);
        chk("stale_dep", 32'(rsDependency[RW-1:0]), 32'd4);
        tick();
        idle();
        settle();
        chk("stale_dirty2", 32'(rsDirty[0]), 32'd1);
        chk("stale_dep2", 32'(rsDependency[RW-1:0]), 32'd4);
        clearIn = 1'b1;
        settle();
        tick();
        idle();
        settle();
        chk("stale_val", rsValue[31:0], 32'hBEEF);
        chk("clr_dirty", 32'(rsDirty[0]), 32'd0);
        tick();

        // Save / commit / restore walk-through
        readyIn  = 1'b1;
        readAddr = {5'd2, 5'd1};
        commit(5'd2, 4'd0, 32'h22);
        settle();
        tick();
        idle();
        rename(5'd1, 4'd1);
        settle();
        tick();
        idle();
        ckptSaveValid = 1'b1;
        ckptSaveId    = 2'd0;
        settle();
        tick();
        idle();
        rename(5'd2, 4'd2);
        settle();
        tick();
        idle();
        commit(5'd1, 4'd1, 32'h111);
        settle();
        tick();
        idle();
        ckptRestoreValid = 1'b1;
        ckptRestoreId    = 2'd0;
        settle();
        tick();
        idle();
        settle();
        chk("ck_x1_dirty", 32'(rsDirty[0]), 32'd0);
        chk("ck_x1_val", rsValue[31:0], 32'h111);
        chk("ck_x2_dirty", 32'(rsDirty[1]), 32'd0);
        chk("ck_x2_val", rsValue[63:32], 32'h22);
        tick();

        // Clear together with a commit; rename of x0
        readyIn  = 1'b1;
        readAddr = {5'd0, 5'd3};
        rename(5'd3, 4'd5);
        settle();
        tick();
        idle();
        clearIn = 1'b1;
        commit(5'd3, 4'd9, 32'h333);
        settle();
        tick();
        idle();
        settle();
        chk("clr_x3_dirty", 32'(rsDirty[0]), 32'd0);
        chk("clr_x3_val", rsValue[31:0], 32'h333);
        readyIn  = 1'b1;
        readAddr = {5'd0, 5'd0};
        rename(5'd0, 4'd6);
        settle();
        tick();
        idle();
        settle();
        chk("x0_dirty", 32'(rsDirty[0]), 32'd0);
        chk("x0_val", rsValue[31:0], 32'd0);
        chk("x0_dep", 32'(rsDependency[RW-1:0]), 32'd0);
        tick();

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [4:0] d;
            idle();
            resetIn = ($urandom_range(0, 249) == 0);
            clearIn = ($urandom_range(0, 39) == 0);
            readyIn = ($urandom_range(0, 2) == 0);
            for (int p = 0; p < RP; p++) begin
                readAddr[5*p +: 5] = ($urandom_range(0, 7) == 0)
                    ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
                robReady[p] = ($urandom_range(0, 3) == 0);
                robValue[32*p +: 32] = $urandom();
            end
            if ($urandom_range(0, 1) == 1)
                rename(5'($urandom_range(0, 7)), RW'($urandom()));
            if ($urandom_range(0, 1) == 1) begin
                d = 5'($urandom_range(0, 7));
                commit(d, ($urandom_range(0, 3) == 0) ? RW'($urandom())
                                                      : mtag[d],
                       $urandom());
            end
            ckptSaveValid    = ($urandom_range(0, 5) == 0);
            ckptSaveId       = CW'($urandom());
            ckptRestoreValid = ($urandom_range(0, 15) == 0);
            ckptRestoreId    = CW'($urandom());
            settle();
            tick();
        end

        idle();
        settle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
